// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the uart_tx byte-channel arbiter.
// FSM encodings and the default channel-ID header base.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [7:0] DEF_HDR_BASE = 8'hF0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... mod N and reports the first request found.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] rot;
    int             ofs;
    int             sum;

    always_comb begin
        any = |req;
        rot = {req, req} >> (32'(last) + 32'd1);
        ofs = 0;
        // Walk downwards so the nearest requester is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ofs = i;
            end
        end
        sum = 32'(last) + 1 + ofs;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = IW'(sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one uart_tx byte channel.
// Optionally prefixes each packet with a channel-ID header byte.
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
    parameter int         N        = 4,
    parameter int         IW       = 2,
    parameter int         HDR_EN   = 1,
    parameter logic [7:0] HDR_BASE = DEF_HDR_BASE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clken,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [IW-1:0]  grant_id,
    output logic           busy
);

    logic [1:0]    state;
    logic [IW-1:0] last_grant;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic [7:0]    own_data;
    logic          own_valid;
    logic          own_last;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        own_data  = 8'h00;
        own_valid = 1'b0;
        own_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IW'(i)) begin
                own_data  = req_data[8*i +: 8];
                own_valid = req_valid[i];
                own_last  = req_last[i];
            end
        end
    end

    // tx_valid depends only on state and the owner's valid, never on tx_ready.
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        case (state)
            ST_HDR: begin
                tx_data  = HDR_BASE | 8'(grant_id);
                tx_valid = 1'b1;
            end
            ST_BODY: begin
                tx_data  = own_data;
                tx_valid = own_valid;
                for (int i = 0; i < N; i++) begin
                    req_ready[i] = (grant_id == IW'(i)) && clken
                                   && tx_ready && own_valid;
                end
            end
            default: begin
                tx_data  = 8'h00;
                tx_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= IW'(N - 1);
        end else if (clken) begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= (HDR_EN != 0) ? ST_HDR : ST_BODY;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        state <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (tx_ready && own_valid && own_last) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (header and no-header builds).
// Producers replay counted packets; tx transfers are logged and compared.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b1;
    logic [31:0] req_data = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic        tx_ready = 1'b1;

    logic [3:0] req_ready, nh_req_ready;
    logic [7:0] tx_data, nh_tx_data;
    logic       tx_valid, nh_tx_valid;
    logic [1:0] grant_id, nh_grant_id;
    logic       busy, nh_busy;

    int checks = 0;
    int failures = 0;

    int base [4];
    int len  [4];
    int cnt  [4];
    int left [4];
    int hold [4];
    int rdy_cnt [4];
    int bad = 0;
    int cyc = 0;
    bit sel = 0;
    bit cpat = 0;
    logic [7:0] txq [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(4), .IW(2), .HDR_EN(1), .HDR_BASE(8'hF0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    uart_tx_arbiter #(.N(4), .IW(2), .HDR_EN(0), .HDR_BASE(8'hF0)) u_nh (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (nh_req_ready),
        .tx_data   (nh_tx_data),
        .tx_valid  (nh_tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (nh_grant_id),
        .busy      (nh_busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (left[i] > 0) && (hold[i] == 0);
            req_data[8*i +: 8] = 8'(base[i] + cnt[i]);
            req_last[i] = (cnt[i] == len[i] - 1);
        end
    endtask

    task automatic cycle();
        logic [3:0] rdy;
        @(negedge clk);
        rdy = sel ? nh_req_ready : req_ready;
        if (sel) begin
            if (clken && nh_tx_valid && tx_ready) txq.push_back(nh_tx_data);
        end else begin
            if (clken && tx_valid && tx_ready) txq.push_back(tx_data);
        end
        if (rdy != 4'd0 && !clken) bad++;
        for (int i = 0; i < 4; i++) if (rdy[i]) rdy_cnt[i]++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                if (cnt[i] == len[i] - 1) begin
                    cnt[i] = 0;
                    left[i]--;
                end else begin
                    cnt[i]++;
                end
            end
        end
        cyc++;
        if (cpat) clken = (cyc % 4 == 0);
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic setp(input int i, input int b, input int l, input int p);
        base[i] = b;
        len[i]  = l;
        left[i] = p;
        cnt[i]  = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            setp(i, 0, 1, 0);
            hold[i] = 0;
            rdy_cnt[i] = 0;
        end
        txq.delete();
        bad = 0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_rdy(input int i, input int n);
        int k;
        k = 0;
        while (rdy_cnt[i] < n && k < 200) begin
            cycle();
            k++;
        end
        chk("wait_rdy_timeout", int'(k < 200), 1);
    endtask

    initial begin
        // reset state
        reset_dut();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant_id, 0);

        // 1: single-byte packet
        reset_dut();
        setp(0, 8'h41, 1, 1);
        drive();
        run(20);
        chk("t1_n", txq.size(), 2);
        chk("t1_b0", txq[0], 8'hF0);
        chk("t1_b1", txq[1], 8'h41);
        chk("t1_rdy", rdy_cnt[0], 1);
        chk("t1_busy", busy, 0);

        // 2: round robin over all four
        reset_dut();
        for (int i = 0; i < 4; i++) setp(i, 8'h20 + 16 * i, 2, 2);
        drive();
        run(60);
        chk("t2_n", txq.size(), 24);
        chk("t2_h0", txq[0], 8'hF0);
        chk("t2_d0", txq[1], 8'h20);
        chk("t2_d1", txq[2], 8'h21);
        chk("t2_h1", txq[3], 8'hF1);
        chk("t2_d2", txq[4], 8'h30);
        chk("t2_h2", txq[6], 8'hF2);
        chk("t2_h3", txq[9], 8'hF3);
        chk("t2_h4", txq[12], 8'hF0);
        chk("t2_d4", txq[13], 8'h20);

        // 3: owner stalls mid-packet, grant is held
        reset_dut();
        setp(1, 8'h50, 3, 1);
        setp(2, 8'h60, 1, 1);
        drive();
        wait_rdy(1, 1);
        hold[1] = 1;
        drive();
        run(50);
        chk("t3_stall_n", txq.size(), 2);
        chk("t3_stall_grant", grant_id, 1);
        chk("t3_stall_busy", busy, 1);
        hold[1] = 0;
        drive();
        run(30);
        chk("t3_n", txq.size(), 6);
        chk("t3_h1", txq[0], 8'hF1);
        chk("t3_d0", txq[1], 8'h50);
        chk("t3_d2", txq[3], 8'h52);
        chk("t3_h2", txq[4], 8'hF2);
        chk("t3_d3", txq[5], 8'h60);

        // 4: no header build
        sel = 1;
        reset_dut();
        setp(3, 8'h10, 3, 1);
        drive();
        run(20);
        chk("t4_n", txq.size(), 3);
        chk("t4_b0", txq[0], 8'h10);
        chk("t4_b1", txq[1], 8'h11);
        chk("t4_b2", txq[2], 8'h12);
        chk("t4_busy", nh_busy, 0);
        chk("t4_rdy", rdy_cnt[3], 3);
        sel = 0;

        // 5: clock enable one cycle in four
        reset_dut();
        setp(0, 8'h70, 2, 1);
        setp(1, 8'h80, 1, 1);
        cyc = 0;
        cpat = 1;
        clken = 1'b1;
        drive();
        run(80);
        cpat = 0;
        clken = 1'b1;
        chk("t5_n", txq.size(), 5);
        chk("t5_h0", txq[0], 8'hF0);
        chk("t5_d0", txq[1], 8'h70);
        chk("t5_d1", txq[2], 8'h71);
        chk("t5_h1", txq[3], 8'hF1);
        chk("t5_d2", txq[4], 8'h80);
        chk("t5_ready_gated", bad, 0);

        // 6: async reset inside a packet
        reset_dut();
        setp(0, 8'h90, 4, 1);
        setp(2, 8'hA0, 1, 1);
        drive();
        wait_rdy(0, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #2;
        chk("t6_busy", busy, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_req_ready", req_ready, 0);
        reset_dut();
        setp(0, 8'h90, 1, 1);
        setp(2, 8'hA0, 1, 1);
        drive();
        run(20);
        chk("t6_h0", txq[0], 8'hF0);
        chk("t6_d0", txq[1], 8'h90);
        chk("t6_h2", txq[2], 8'hF2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
